sdram_vid_fetch: RTL and testbench

- Video-side initiator for the video read port of the 32r8w SDRAM controller.
- On each line-start pulse it fetches a run of 32-bit pairs from SDRAM through the controller's req/ack/ready handshake.
- It buffers the 16-bit words in a small FIFO and presents them to the pixel pipeline first-word-fall-through.
- It sits between the SDRAM controller's video port and the CoCo3 video shifter.

---
 rtl/sdram_vid_pkg.sv | 21 ++
 rtl/vid_line_fifo.sv | 65 ++++++
 rtl/sdram_vid_fetch.sv | 175 +++++++++++++++++
 tb/tb_sdram_vid_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_vid_pkg.sv
// sdram_vid_pkg: shared types and constants for the SDRAM video fetch block.
// Optional build macro used by the block: VID_FETCH_TIMEOUT_EN.
package sdram_vid_pkg;

  localparam int ADDR_W_DEF  = 25;
  localparam int LEN_W_DEF   = 10;
  localparam int FIFO_AW_DEF = 4;
  localparam int TMO_CYC_DEF = 32;

  // One controller read returns a 32-bit pair as two 16-bit words.
  localparam int WORDS_PER_REQ = 2;
  localparam int BYTES_PER_REQ = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } vid_state_e;

endpackage

// File: rtl/vid_line_fifo.sv
// vid_line_fifo: small synchronous first-word-fall-through FIFO with flush,
// occupancy output and a sticky underrun flag (read while empty).
module vid_line_fifo #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          valid,
  output logic [AW:0]   count,
  output logic          underrun
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          underrun_reg;
  logic          empty, full, push, pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign push  = wr_en & ~full & ~srst & ~flush;
  assign pop   = rd_en & ~empty & ~srst & ~flush;

  // Word storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky underrun, cleared by reset or a flush at line start.
  always_ff @(posedge clk) begin
    if (srst || flush)      underrun_reg <= 1'b0;
    else if (rd_en && empty) underrun_reg <= 1'b1;
  end

  assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
  assign valid    = ~empty;
  assign count    = count_reg;
  assign underrun = underrun_reg;

endmodule

// File: rtl/sdram_vid_fetch.sv
// sdram_vid_fetch: per-line video read initiator for the SDRAM controller's
// video port. Fetches 32-bit pairs via req/ack/ready and hands 16-bit words
// to the pixel pipeline through a FWFT FIFO.
// Optional macro VID_FETCH_TIMEOUT_EN adds a watchdog and the tmo_err output.
module sdram_vid_fetch
  import sdram_vid_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              init,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic [LEN_W-1:0]  line_pairs,
  output logic              sdram_vid_req,
  output logic [ADDR_W-1:0] sdram_vid_addr,
  input  logic              sdram_vid_ack,
  input  logic              sdram_vid_ready,
  input  logic [15:0]       sdram_dout,
  input  logic              pix_rd,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  output logic              fetch_busy,
  output logic              line_done,
  output logic              underrun
`ifdef VID_FETCH_TIMEOUT_EN
  ,
  output logic              tmo_err
`endif
);

  vid_state_e        state_reg;
  logic [ADDR_W-1:0] base_reg, addr_reg, pend_base_reg;
  logic [LEN_W-1:0]  rem_reg, pend_len_reg;
  logic              pend_reg, word_reg, req_reg, busy_reg, done_reg;
  logic [FIFO_AW:0]  fifo_count;
  logic              start_now, free_ok, fifo_wr, tmo_hit;
  logic [ADDR_W-1:0] start_base;
  logic [LEN_W-1:0]  start_len;

  // A new line is taken only in S_IDLE; a fresh pulse beats a pending one.
  assign start_now  = (state_reg == S_IDLE) && (line_start || pend_reg);
  assign start_base = line_start ? (line_base & ~ADDR_W'(3)) : pend_base_reg;
  assign start_len  = line_start ? line_pairs : pend_len_reg;
  // Request only when the whole pair is guaranteed to fit.
  assign free_ok    = fifo_count <= (FIFO_AW+1)'((1 << FIFO_AW) - WORDS_PER_REQ);
  assign fifo_wr    = (state_reg == S_DATA) && sdram_vid_ready && !tmo_hit;

`ifdef VID_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_err_reg;

  assign tmo_hit = ((state_reg == S_REQ) || (state_reg == S_DATA)) &&
                   (tmo_cnt_reg == TW'(TMO_CYC - 1));
  assign tmo_err = tmo_err_reg;

  // Watchdog: counts clocks spent waiting on the controller.
  always_ff @(posedge clk) begin
    if (init || !((state_reg == S_REQ) || (state_reg == S_DATA)))
      tmo_cnt_reg <= '0;
    else
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Fetch sequencer: line start/pending, request handshake and pair capture.
  always_ff @(posedge clk) begin
    if (init) begin
      state_reg     <= S_IDLE;
      base_reg      <= '0;
      addr_reg      <= '0;
      rem_reg       <= '0;
      pend_reg      <= 1'b0;
      pend_base_reg <= '0;
      pend_len_reg  <= '0;
      word_reg      <= 1'b0;
      req_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef VID_FETCH_TIMEOUT_EN
      tmo_err_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (line_start && state_reg != S_IDLE) begin
        pend_reg      <= 1'b1;
        pend_base_reg <= line_base & ~ADDR_W'(3);
        pend_len_reg  <= line_pairs;
      end
      case (state_reg)
        S_IDLE: begin
          if (start_now) begin
            base_reg <= start_base;
            rem_reg  <= start_len;
            pend_reg <= 1'b0;
            busy_reg <= (start_len != '0);
            done_reg <= (start_len == '0);
`ifdef VID_FETCH_TIMEOUT_EN
            tmo_err_reg <= 1'b0;
`endif
          end else if (rem_reg != '0 && free_ok && !sdram_vid_ack) begin
            state_reg <= S_REQ;
            req_reg   <= 1'b1;
            addr_reg  <= base_reg;
          end
        end
        S_REQ: begin
          if (sdram_vid_ack) begin
            req_reg   <= 1'b0;
            word_reg  <= 1'b0;
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (sdram_vid_ready) begin
            if (word_reg) begin
              base_reg  <= base_reg + ADDR_W'(BYTES_PER_REQ);
              rem_reg   <= rem_reg - LEN_W'(1);
              word_reg  <= 1'b0;
              state_reg <= S_GAP;
            end else begin
              word_reg <= 1'b1;
            end
          end
        end
        default: begin
          if (!sdram_vid_ack) begin
            state_reg <= S_IDLE;
            if (rem_reg == '0) begin
              done_reg <= 1'b1;
              busy_reg <= 1'b0;
            end
          end
        end
      endcase
`ifdef VID_FETCH_TIMEOUT_EN
      if (tmo_hit) begin
        tmo_err_reg <= 1'b1;
        req_reg     <= 1'b0;
        word_reg    <= 1'b0;
        rem_reg     <= '0;
        state_reg   <= S_GAP;
      end
`endif
    end
  end

  vid_line_fifo #(
    .AW(FIFO_AW),
    .DW(16)
  ) u_fifo (
    .clk     (clk),
    .srst    (init),
    .flush   (start_now),
    .wr_en   (fifo_wr),
    .wr_data (sdram_dout),
    .rd_en   (pix_rd),
    .rd_data (pix_data),
    .valid   (pix_valid),
    .count   (fifo_count),
    .underrun(underrun)
  );

  assign sdram_vid_req  = req_reg;
  assign sdram_vid_addr = addr_reg;
  assign fetch_busy     = busy_reg;
  assign line_done      = done_reg;

endmodule

// File: tb/tb_sdram_vid_fetch.sv
// tb_sdram_vid_fetch: directed and randomized checks of sdram_vid_fetch
// against a line-level model (expected request addresses and word stream).
module tb_sdram_vid_fetch;

  logic        clk, init, line_start, pix_rd;
  logic [24:0] line_base, sdram_vid_addr;
  logic [9:0]  line_pairs;
  logic        sdram_vid_req, sdram_vid_ack, sdram_vid_ready;
  logic [15:0] sdram_dout, pix_data;
  logic        pix_valid, fetch_busy, line_done, underrun;
`ifdef VID_FETCH_TIMEOUT_EN
  logic        tmo_err;
`endif

  logic [24:0] req_q[$];
  logic [24:0] exp_req[$];
  logic [15:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  bit ctl_en = 1'b1;

  sdram_vid_fetch dut (
    .clk(clk), .init(init), .line_start(line_start), .line_base(line_base),
    .line_pairs(line_pairs), .sdram_vid_req(sdram_vid_req),
    .sdram_vid_addr(sdram_vid_addr), .sdram_vid_ack(sdram_vid_ack),
    .sdram_vid_ready(sdram_vid_ready), .sdram_dout(sdram_dout),
    .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
    .fetch_busy(fetch_busy), .line_done(line_done), .underrun(underrun)
`ifdef VID_FETCH_TIMEOUT_EN
    , .tmo_err(tmo_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM contents as seen by the video port.
  function automatic logic [15:0] word_at(input logic [24:0] a);
    return a[16:1] ^ {a[24:17], a[8:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: ack 4 clocks after req, two ready strobes 3 and 4 clocks after ack.
  initial begin
    logic [24:0] a;
    sdram_vid_ack = 1'b0; sdram_vid_ready = 1'b0; sdram_dout = 16'h0;
    forever begin
      @(negedge clk);
      if (ctl_en && sdram_vid_req === 1'b1) begin
        a = sdram_vid_addr;
        req_q.push_back(a);
        $display("req   addr=%07h", a);
        repeat (3) @(negedge clk);
        sdram_vid_ack = 1'b1;
        @(negedge clk);
        sdram_vid_ack = 1'b0;
        chk("req_fall", 32'(sdram_vid_req), 32'd0);
        repeat (2) @(negedge clk);
        sdram_vid_ready = 1'b1; sdram_dout = word_at(a);
        @(negedge clk);
        sdram_dout = word_at(a + 25'd2);
        @(negedge clk);
        sdram_vid_ready = 1'b0; sdram_dout = 16'h0;
      end
    end
  end

  // Line completion monitor.
  initial forever begin
    @(negedge clk);
    if (line_done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  // Pulse line_start and build the expected requests and word stream.
  task automatic start_line(input logic [24:0] base, input int pairs, input bit keep_reqs);
    logic [24:0] a;
    @(negedge clk);
    pix_rd = 1'b0;
    line_start = 1'b1; line_base = base; line_pairs = 10'(pairs);
    if (!keep_reqs) begin req_q.delete(); exp_req.delete(); end
    exp_q.delete();
    done_cnt = 0;
    for (int k = 0; k < pairs; k++) begin
      a = (base & ~25'd3) + 25'(4 * k);
      exp_req.push_back(a);
      exp_q.push_back(word_at(a));
      exp_q.push_back(word_at(a + 25'd2));
    end
    @(negedge clk);
    line_start = 1'b0;
    $display("line  base=%07h pairs=%0d", base, pairs);
  endtask

  // One clock of the pixel reader; pops with the given percent probability.
  task automatic step(input int prob);
    @(negedge clk);
    pix_rd = 1'b0;
    if (pix_valid && int'($urandom_range(99)) < prob) begin
      if (exp_q.size() == 0) chk("fifo_extra", 32'(pix_valid), 32'd0);
      else begin
        chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        pix_rd = 1'b1;
      end
    end
  endtask

  task automatic chk_reqs(input string tag);
    chk({tag, "_nreq"}, 32'(req_q.size()), 32'(exp_req.size()));
    for (int i = 0; i < req_q.size() && i < exp_req.size(); i++)
      chk({tag, "_addr"}, 32'(req_q[i]), 32'(exp_req[i]));
  endtask

  task automatic drain(input string tag, input int prob);
    for (int c = 0; c < 800; c++) begin
      step(prob);
      if (done_cnt >= 1 && exp_q.size() == 0 && !fetch_busy) break;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(fetch_busy), 32'd0);
    chk_reqs(tag);
  endtask

  initial begin
    init = 1'b1; line_start = 1'b0; line_base = '0; line_pairs = '0; pix_rd = 1'b0;
    repeat (3) @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(sdram_vid_req), 32'd0);
    chk("rst_addr", 32'(sdram_vid_addr), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_done", 32'(line_done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
`ifdef VID_FETCH_TIMEOUT_EN
    chk("rst_tmo", 32'(tmo_err), 32'd0);
`endif

    // Single pair.
    start_line(25'h0001000, 1, 1'b0);
    chk("single_busy", 32'(fetch_busy), 32'd1);
    drain("single", 100);

    // Slow reader: FIFO fills after 8 pairs, two pops release request 9.
    start_line(25'h0001000, 10, 1'b0);
    repeat (150) step(0);
    chk("slow_nreq8", 32'(req_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < req_q.size(); i++)
      chk("slow_addr", 32'(req_q[i]), 32'(exp_req[i]));
    chk("slow_req_low", 32'(sdram_vid_req), 32'd0);
    step(100); step(100);
    repeat (20) step(0);
    chk("slow_nreq9", 32'(req_q.size()), 32'd9);
    if (req_q.size() >= 9) chk("slow_addr9", 32'(req_q[8]), 32'h1020);
    drain("slow", 100);

    // Address wrap.
    start_line(25'h1FFFFFC, 2, 1'b0);
    drain("wrap", 60);

    // Pending start during the first pair of line A.
    start_line(25'h0002000, 3, 1'b0);
    for (int c = 0; c < 50 && sdram_vid_ready !== 1'b1; c++) step(0);
    exp_req.delete(); exp_req.push_back(25'h0002000);
    start_line(25'h0003000, 2, 1'b1);
    repeat (10) step(0);
    drain("pending", 100);

    // Zero-length line.
    start_line(25'h0000400, 0, 1'b0);
    chk("zero_done", 32'(line_done), 32'd1);
    repeat (10) step(0);
    chk_reqs("zero");

    // Underrun set by a read on empty, cleared by next line start.
    @(negedge clk); pix_rd = 1'b1;
    @(negedge clk); pix_rd = 1'b0;
    chk("underrun_set", 32'(underrun), 32'd1);
    start_line(25'h0000400, 0, 1'b0);
    chk("underrun_clr", 32'(underrun), 32'd0);

    // Reset in the middle of a data phase; the stray strobe must not land.
    start_line(25'h0004000, 2, 1'b0);
    for (int c = 0; c < 50 && sdram_vid_ready !== 1'b1; c++) step(0);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init_req", 32'(sdram_vid_req), 32'd0);
    chk("init_addr", 32'(sdram_vid_addr), 32'd0);
    chk("init_valid", 32'(pix_valid), 32'd0);
    chk("init_busy", 32'(fetch_busy), 32'd0);
    chk("init_underrun", 32'(underrun), 32'd0);
    step(0);
    chk("init_stray", 32'(pix_valid), 32'd0);
    repeat (10) step(0);
    chk("init_nreq", 32'(req_q.size()), 32'd1);

    // Randomized lines.
    for (int n = 0; n < 6; n++) begin
      start_line(25'($urandom), int'($urandom_range(1, 12)), 1'b0);
      drain("rand", int'($urandom_range(20, 100)));
    end

`ifdef VID_FETCH_TIMEOUT_EN
    ctl_en = 1'b0;
    start_line(25'h0005000, 1, 1'b0);
    repeat (45) step(0);
    chk("tmo_err", 32'(tmo_err), 32'd1);
    chk("tmo_req", 32'(sdram_vid_req), 32'd0);
    chk("tmo_done", 32'(done_cnt), 32'd1);
    chk("tmo_busy", 32'(fetch_busy), 32'd0);
    ctl_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
